ram_port_sequencer: RTL
=======================

// Module: ram_port_sequencer
// PURPOSE
//   Single owner of the 32x8 single-port RAM (ramlpm) port.
//   Turns a user write request (switch level) into one clean write cycle.
//   Performs a periodic scan read, plus a read-back after every write.
//   Presents the read address/data to the HEX display stage as registered values with a valid strobe.
//   Sits between the switch/LED top level and the ramlpm instance + HEX_to_seven_segment decoders.
// PARAMETERS
//   ADDR_W    5           RAM address width (depth 2**ADDR_W)
//   DATA_W    8           RAM data width
//   SCAN_DIV  50_000_000  CLOCK_50 cycles between scan reads (1 Hz); >= 2
//   RD_LAT    2           cycles from ram_address driven to ram_q valid; >= 1
// PORTS
//   CLOCK_50     in   1       system clock, all logic on rising edge
//   rst_n        in   1       asynchronous active-low reset
//   wr_req       in   1       write request level (already synchronous); acts on rising edge
//   wr_addr      in   ADDR_W  write address, sampled on wr_req rising edge
//   wr_data      in   DATA_W  write data, sampled on wr_req rising edge
//   ram_address  out  ADDR_W  RAM address
//   ram_data     out  DATA_W  RAM write data
//   ram_wren     out  1       RAM write enable
//   ram_q        in   DATA_W  RAM read data
//   disp_addr    out  ADDR_W  address of last completed read
//   disp_data    out  DATA_W  data of last completed read
//   disp_valid   out  1       1-cycle pulse when disp_addr/disp_data update
//   busy         out  1       high whenever FSM is not IDLE
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - All outputs 0; FSM=IDLE; scan counter=0; scan_addr=0; pending flags clear.
//   - wr_req_prev resets to 1: wr_req high at reset release produces NO write.
//   Edge detect:
//   - wr_edge = wr_req & ~wr_req_prev.
//   - On wr_edge with wr_pend=0: wr_pend<=1 and wr_addr/wr_data captured into hold regs.
//   - wr_edge while wr_pend=1 is dropped; first request wins.
//   Scan timer:
//   - Counts 0..SCAN_DIV-1, then wraps to 0.
//   - At SCAN_DIV-1 sets scan_pend.
//   - A tick while scan_pend=1 merges: only one read is performed.
//   FSM states IDLE, WRITE, READ, CAPTURE:
//   - IDLE:
//     - wr_pend -> WRITE (writes have priority over scan).
//     - else scan_pend -> READ with target=scan_addr, scan_pend<=0.
//   - WRITE (1 cycle):
//     - ram_address=hold_addr, ram_data=hold_data, ram_wren=1; wr_pend<=0.
//     - -> READ with target=hold_addr (read-back).
//   - READ:
//     - ram_address=target, ram_wren=0; wait RD_LAT cycles, then -> CAPTURE.
//   - CAPTURE (1 cycle):
//     - disp_addr<=target, disp_data<=ram_q, disp_valid=1 -> IDLE.
//     - If the read was a scan read, scan_addr<=scan_addr+1 (mod 2**ADDR_W; 31->0).
//     - Read-back does not advance scan_addr.
//   Timing and hold:
//   - Write-to-display latency: 1 (edge reg) + 1 (WRITE) + RD_LAT + 1 (CAPTURE) cycles.
//   - ram_wren high for exactly one cycle per accepted request.
//   - ram_data is 0 outside WRITE.
//   - ram_address holds its last value in IDLE.
//   Concurrency:
//   - New edges and ticks arriving while busy are still latched into pending flags.
//   - They are served on return to IDLE, in priority order.
//   - Simultaneous edge and tick in one cycle: write + read-back first, then scan read.
//   Reset mid-operation:
//   - Aborts immediately; ram_wren drops asynchronously; pending work is discarded.
// TESTING (SCAN_DIV=8, RD_LAT=2, behavioural RAM model with 2-cycle read latency)
//   Reset release with wr_req=1 -> no ram_wren pulse; first scan reads addr 0 at cycle 8.
//   wr_req 0->1 with addr=5, data=0xA5 -> one ram_wren cycle at addr 5;
//     disp_addr=5, disp_data=0xA5, disp_valid pulse after 5 cycles.
//   Edge and scan tick in same cycle -> write+read-back completes first,
//     then scan read of scan_addr; scan_addr advances only once.
//   Run 33 scan ticks with no writes -> disp_addr sequence 0..31 then 0 (wrap).
//   Two wr_req edges before the first write is served -> only the first address/data is written.
//   Assert rst_n during READ -> all outputs 0 immediately;
//     after release FSM is IDLE and scan restarts at addr 0.

Source files
------------

// File: rtl/ram_port_sequencer.sv
// Sole owner of the single-port RAM: turns write requests into one write cycle plus read-back,
// runs a periodic address scan, and hands each completed read to the display stage.
module ram_port_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int SCAN_DIV = 50_000_000,
  parameter int RD_LAT   = 2
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              busy
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, CAPTURE} state_t;

  state_t            state;
  state_t            state_next;
  logic              wr_req_prev;
  logic              wr_pend;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic [CNT_W-1:0]  scan_cnt;
  logic              scan_pend;
  logic [ADDR_W-1:0] scan_addr;
  logic [ADDR_W-1:0] target;
  logic              is_scan;
  logic [LAT_W-1:0]  lat_cnt;
  logic              wr_edge;
  logic              scan_tick;
  logic              start_write;
  logic              start_scan;

  assign wr_edge   = wr_req & ~wr_req_prev;
  assign scan_tick = (scan_cnt == SCAN_LAST);
  assign busy      = (state != IDLE);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Write enable and data come straight from the state so reset removes them asynchronously.
  always_comb begin
    state_next  = state;
    ram_wren    = 1'b0;
    ram_data    = '0;
    start_write = 1'b0;
    start_scan  = 1'b0;
    case (state)
      IDLE: begin
        if (wr_pend) begin
          state_next  = WRITE;
          start_write = 1'b1;
        end else if (scan_pend) begin
          state_next = READ;
          start_scan = 1'b1;
        end
      end
      WRITE: begin
        ram_wren   = 1'b1;
        ram_data   = hold_data;
        state_next = READ;
      end
      READ: begin
        if (lat_cnt == LAT_LAST) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // wr_req_prev starts high so a request already asserted at reset release is ignored.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      wr_req_prev <= 1'b1;
      wr_pend     <= 1'b0;
      hold_addr   <= '0;
      hold_data   <= '0;
      scan_cnt    <= '0;
      scan_pend   <= 1'b0;
    end else begin
      wr_req_prev <= wr_req;
      if (state == WRITE) begin
        wr_pend <= 1'b0;
      end else if (wr_edge && !wr_pend) begin
        wr_pend   <= 1'b1;
        hold_addr <= wr_addr;
        hold_data <= wr_data;
      end
      scan_cnt <= scan_tick ? '0 : scan_cnt + CNT_W'(1);
      if (scan_tick) begin
        scan_pend <= 1'b1;
      end else if (start_scan) begin
        scan_pend <= 1'b0;
      end
    end
  end

  // ram_address is only loaded when an access starts, so it holds its last value while idle.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      ram_address <= '0;
      target      <= '0;
      is_scan     <= 1'b0;
      lat_cnt     <= '0;
      scan_addr   <= '0;
      disp_addr   <= '0;
      disp_data   <= '0;
      disp_valid  <= 1'b0;
    end else begin
      disp_valid <= 1'b0;
      if (start_write) begin
        ram_address <= hold_addr;
        target      <= hold_addr;
        is_scan     <= 1'b0;
      end else if (start_scan) begin
        ram_address <= scan_addr;
        target      <= scan_addr;
        is_scan     <= 1'b1;
      end
      if (state == READ) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end else begin
        lat_cnt <= '0;
      end
      if (state == CAPTURE) begin
        disp_addr  <= target;
        disp_data  <= ram_q;
        disp_valid <= 1'b1;
        if (is_scan) begin
          scan_addr <= scan_addr + ADDR_W'(1);
        end
      end
    end
  end

endmodule
